// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Purpose  : Fetch-stage bundle: instruction-memory port, redirect input and
//            the {instr, pc} handshake toward decode.
// Revision : 1.0
// ============================================================================
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : RV32I fetch stage; credit-limited imem requests, in-order response
//            FIFO toward decode, redirect flush via a discard counter.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    instr_fetch_if.master bus
);
    localparam int unsigned     c_PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned     c_CW      = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(FIFO_DEPTH);
    localparam logic [31:0]     c_BOOT_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [0:0] {
        ST_BOOT  = 1'b0,
        ST_FETCH = 1'b1
    } state_e;

    state_e          state_q;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [c_CW-1:0] outst_q, outst_d;
    logic [c_CW-1:0] discard_q, discard_d;
    logic [c_CW-1:0] count_q, count_d;
    logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]     data_q [FIFO_DEPTH];
    logic [31:0]     pc_q   [FIFO_DEPTH];

    logic            w_req, w_fire, w_valid, w_pop, w_drop, w_push;
    logic [31:0]     w_target;

    // Credits cover both in-flight requests and buffered words, so a push always finds room.
    assign w_target = {bus.redirect_pc[31:2], 2'b00};
    assign w_req    = (state_q == ST_FETCH) && !bus.redirect && ((outst_q + count_q) < c_DEPTH);
    assign w_fire   = w_req && bus.imem_gnt;
    assign w_valid  = (count_q != '0) && !bus.redirect;
    assign w_pop    = w_valid && bus.instr_ready;
    assign w_drop   = bus.imem_rvalid && (discard_q != '0);
    assign w_push   = bus.imem_rvalid && !w_drop && !bus.redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q + c_CW'(w_fire) - c_CW'(bus.imem_rvalid);
        discard_d  = discard_q;
        count_d    = count_q + c_CW'(w_push) - c_CW'(w_pop);
        wr_ptr_d   = wr_ptr_q + c_PW'(w_push);
        rd_ptr_d   = rd_ptr_q + c_PW'(w_pop);
        if (bus.redirect) begin
            // No grant can happen here, so outst_d is what is still in flight.
            fetch_pc_d = w_target;
            rsp_pc_d   = w_target;
            discard_d  = outst_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (w_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (w_drop) discard_d  = discard_q - c_CW'(1);
            if (w_push) rsp_pc_d   = rsp_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            case (state_q)
                ST_BOOT:  state_q <= ST_FETCH;
                default:  state_q <= ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= c_BOOT_PC;
            rsp_pc_q   <= c_BOOT_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q[gi] <= '0;
                pc_q[gi]   <= '0;
            end else if (w_push && (wr_ptr_q == c_PW'(gi))) begin
                data_q[gi] <= bus.imem_rdata;
                pc_q[gi]   <= rsp_pc_q;
            end
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = w_valid;
    assign bus.instr_data  = data_q[rd_ptr_q];
    assign bus.instr_pc    = pc_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage of the RV32I core. Directly upstream of the decoder that uses the `rv32i_instr_e` enum and opcode constants.
- Issues word requests to instruction memory and buffers returned words in a small FIFO. Hands {instr, pc} pairs to decode over a valid/ready handshake.
- On a redirect (taken branch, JAL/JALR), flushes buffered and in-flight words and restarts at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 2: buffer entries; also the maximum number of outstanding memory requests (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  request valid.
- imem_addr  out  32  word address; bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response valid. Responses arrive in order, at least 1 cycle after the grant.
- imem_rdata  in  32  response word.
- redirect  in  1  redirect request, 1-cycle pulse.
- redirect_pc  in  32  target; bits [1:0] ignored (forced 0).
- instr_valid  out  1  FIFO head valid to decode.
- instr_ready  in  1  decode accepts the head.
- instr_data  out  32  instruction word at the head.
- instr_pc  out  32  address of instr_data.

Behaviour:
- Reset (asynchronous assert; takes effect on the edge after deassert):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0.
  - FIFO empty, outstanding=0, discard=0, fetch_pc=RESET_PC.
- Reset mid-operation: all state cleared immediately. In-flight responses arriving after reset release are counted as stale only if discard was loaded; otherwise memory is required to be reset together with this block.
- States:
  - BOOT (the single cycle after reset release): imem_req=0. Next state FETCH.
  - FETCH: normal operation; stays in FETCH forever. Flushing is handled by the discard counter, not by a separate state.
- Request issue:
  - imem_req=1 when outstanding + fifo_count < FIFO_DEPTH and redirect=0.
  - imem_addr=fetch_pc.
  - On req&gnt: fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0) and outstanding++.
  - While req=1 and gnt=0, addr is held stable.
  - The only case where req may drop without a grant is the redirect cycle.
- Response:
  - On rvalid: outstanding--.
  - If discard>0: discard--, word dropped.
  - Otherwise: {rdata, pc_of_response} is pushed into the FIFO.
  - pc_of_response is tracked by a response-PC register that increments by 4 per non-discarded response and is loaded on redirect.
- Decode handshake:
  - instr_valid = FIFO non-empty and redirect=0.
  - Pop on instr_valid&instr_ready.
  - instr_data and instr_pc come from the FIFO head, registered storage. Minimum latency: rvalid at cycle N -> instr_valid at N+1.
  - Push and pop in the same cycle are allowed.
  - The FIFO can never overflow because of the credit rule.
- Redirect (cycle R):
  - imem_req forced 0 and instr_valid forced 0.
  - FIFO cleared at the R edge.
  - discard <= outstanding after R's own rvalid decrement. An rvalid in cycle R is dropped.
  - fetch_pc and response-PC <= {redirect_pc[31:2],2'b00}.
  - R+1: imem_req may assert with the new address, even while discard>0.
- Redirect during a discard phase: discard is reloaded from the current outstanding count.
- Back-to-back redirects: the last one wins.
- Counters are clog2(FIFO_DEPTH)+1 bits wide.

Test Plan:
- Reset release with gnt=1 and rvalid 1 cycle after each grant, ready=1:
  - Requests go to 0x0, 0x4, 0x8, ...
  - instr_pc sequence is 0x0, 0x4, 0x8.
  - First instr_valid appears 3 cycles after reset release.
- ready=0 with FIFO_DEPTH=2:
  - Exactly 2 grants, then imem_req=0.
  - Raise ready: the 2 words are delivered in order, then requests resume at 0x8.
- Two requests outstanding (0x10, 0x14), redirect_pc=0x103:
  - Next request addr is 0x100.
  - Responses for 0x10 and 0x14 are dropped.
  - First delivered instr_pc=0x100.
- rvalid and redirect in the same cycle:
  - The word is dropped; no stale instr_valid appears.
  - Discard equals the remaining outstanding count (check with 1 remaining).
- imem_gnt held 0 for 5 cycles:
  - imem_req stays 1 and imem_addr stays stable at 0x20.
  - Grant on cycle 6 is followed by 0x24.
- Fetch near the top of memory: sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Then assert rst mid-stream: outputs return to reset values immediately and the next request addr is RESET_PC.
